view_config_ctrl: RTL

- Camera/view configuration controller for the perspective map renderer.
- Turns held user buttons into rate-limited steps of far/near view magnitude and camera heading, with range clamps and heading wrap-around.
- Holds the new values in shadow registers and commits them, together with a sampled ball position, once per frame in vertical blanking. The renderer therefore never sees parameters change mid-frame (no tearing).

---
 rtl/view_config_ctrl.sv | 72 +++++++
 1 files changed

// File: rtl/view_config_ctrl.sv
// view_config_ctrl: rate-limited camera/view parameter stepping with per-frame commit in vertical blanking
module view_config_ctrl #(
    parameter int REPEAT_TICKS = 100000,
    parameter int FAR_RESET    = 17,
    parameter int NEAR_RESET   = 0,
    parameter int MAG_MAX      = 255,
    parameter int FRAME_LINE   = 720
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [5:0]  btn_in,
    input  logic [15:0] ballx_in,
    input  logic [15:0] bally_in,
    output logic [15:0] angle_out,
    output logic [15:0] far_mag_out,
    output logic [15:0] near_mag_out,
    output logic [15:0] ballx_out,
    output logic [15:0] bally_out,
    output logic        frame_update_out
);
    logic [2:0]  step;
    logic [15:0] angle, far_mag, near_mag, far_c, near_c, far_nx, near_nx, angle_nx;
    logic        commit;
    assign commit = hcount_in == 11'd0 && vcount_in == 10'(FRAME_LINE);
    for (genvar g = 0; g < 3; g++) begin : g_grp
        logic [31:0] cnt;
        logic        one;
        assign one     = btn_in[2*g] ^ btn_in[2*g+1];
        assign step[g] = one && (cnt == 32'd0 || cnt == 32'(REPEAT_TICKS));
        always_ff @(posedge pixel_clk_in)
            if (rst_in || !one) cnt <= '0;
            else cnt <= step[g] ? 32'd1 : cnt + 32'd1;
    end
    // near is dropped when its candidate would cross the far candidate
    always_comb begin
        far_c    = (step[0] && btn_in[0] && far_mag < 16'(MAG_MAX)) ? far_mag + 16'd1 :
                   (step[0] && btn_in[1] && far_mag > near_mag)     ? far_mag - 16'd1 : far_mag;
        near_c   = (step[1] && btn_in[2] && near_mag < far_mag) ? near_mag + 16'd1 :
                   (step[1] && btn_in[3] && near_mag > 16'd0)   ? near_mag - 16'd1 : near_mag;
        far_nx   = far_c;
        near_nx  = near_c > far_c ? near_mag : near_c;
        angle_nx = (step[2] && btn_in[4]) ? (angle == 16'd359 ? 16'd0 : angle + 16'd1) :
                   (step[2] && btn_in[5]) ? (angle == 16'd0 ? 16'd359 : angle - 16'd1) : angle;
    end
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            angle            <= '0;
            far_mag          <= 16'(FAR_RESET);
            near_mag         <= 16'(NEAR_RESET);
            angle_out        <= '0;
            far_mag_out      <= 16'(FAR_RESET);
            near_mag_out     <= 16'(NEAR_RESET);
            ballx_out        <= '0;
            bally_out        <= '0;
            frame_update_out <= 1'b0;
        end else begin
            angle            <= angle_nx;
            far_mag          <= far_nx;
            near_mag         <= near_nx;
            frame_update_out <= commit;
            if (commit) begin
                angle_out    <= angle_nx;
                far_mag_out  <= far_nx;
                near_mag_out <= near_nx;
                ballx_out    <= ballx_in;
                bally_out    <= bally_in;
            end
        end
    end
endmodule
